// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_access_ctrl_pkg
// Brief  : Shared FSM encodings and default geometry for the data-RAM front end.
// Rev    : 1.0  initial release
// ============================================================================
package ram_access_ctrl_pkg;

    localparam int              c_ADDR_W_DEFAULT       = 8;
    localparam int              c_DATA_W_DEFAULT       = 8;
    localparam int              c_DEPTH_DEFAULT        = 256;
    localparam int              c_READ_LATENCY_DEFAULT = 1;
    localparam logic [7:0]      c_CLEAR_VALUE_DEFAULT  = 8'h00;
    localparam int              c_LAT_CNT_W            = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    // Load value for the read-latency down-counter; capture happens when it reaches 0.
    function automatic logic [c_LAT_CNT_W-1:0] lat_load(input int latency);
        return c_LAT_CNT_W'(latency);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ram_access_ctrl_if
// Brief  : CPU request/response, clear-sweep control and RAM pin bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface ram_access_ctrl_if
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, clr_start, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, clr_busy, clr_done,
               ram_we, ram_addr, ram_wdata
    );

    // CPU core and RAM side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, clr_start, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, clr_busy, clr_done,
               ram_we, ram_addr, ram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl_clear_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module : clear_sweep_counter
// Brief  : Clear-sweep address counter with terminal-count compare and done pulse.
// Rev    : 1.0  initial release
// ============================================================================
module clear_sweep_counter
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DEPTH  = c_DEPTH_DEFAULT
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_start,
    input  wire               i_step,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_addr_next,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_done;

    // Terminal compare only: the counter never relies on ADDR_W wrap-around.
    assign o_last      = (r_addr == c_LAST_ADDR);
    assign o_addr_next = o_last ? '0 : r_addr + ADDR_W'(1);
    assign o_done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_addr <= '0;
            end else if (i_step) begin
                r_addr <= o_addr_next;
                r_done <= o_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ram_access_ctrl
// Brief  : Single-request CPU front end for a synchronous data RAM, with a
//          hardware clear sweep. All RAM-side pins are registered.
// Rev    : 1.0  initial release
// ============================================================================
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int                DATA_W       = c_DATA_W_DEFAULT,
    parameter int                DEPTH        = c_DEPTH_DEFAULT,
    parameter int                READ_LATENCY = c_READ_LATENCY_DEFAULT,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = DATA_W'(c_CLEAR_VALUE_DEFAULT)
) (
    input  wire              clk,
    input  wire              rst,
    ram_access_ctrl_if.slave bus
);

    localparam logic [c_LAT_CNT_W-1:0] c_LAT_LOAD = lat_load(READ_LATENCY);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_ram_we,    w_ram_we;
    logic [ADDR_W-1:0]        r_ram_addr,  w_ram_addr;
    logic [DATA_W-1:0]        r_ram_wdata, w_ram_wdata;
    logic                     r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0]        r_rsp_rdata, w_rsp_rdata;
    logic                     r_clr_busy,  w_clr_busy;
    logic [c_LAT_CNT_W-1:0]   r_lat_cnt,   w_lat_cnt;
    logic                     w_sweep_start;
    logic                     w_sweep_step;
    logic                     w_sweep_last;
    logic [ADDR_W-1:0]        w_sweep_next;
    logic                     w_clr_done;
    logic                     w_req_ready;

    clear_sweep_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sweep (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_sweep_start),
        .i_step      (w_sweep_step),
        .o_last      (w_sweep_last),
        .o_addr_next (w_sweep_next),
        .o_done      (w_clr_done)
    );

    // A pending clear start steals the IDLE slot, so the request is held off.
    assign w_req_ready = (r_state == ST_IDLE) && !rst && !bus.clr_start;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.clr_busy  = r_clr_busy;
    assign bus.clr_done  = w_clr_done;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_clr_busy  <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ram_we    <= w_ram_we;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_clr_busy  <= w_clr_busy;
            r_lat_cnt   <= w_lat_cnt;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ram_we      = 1'b0;
        w_ram_addr    = r_ram_addr;
        w_ram_wdata   = r_ram_wdata;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_clr_busy    = 1'b0;
        w_lat_cnt     = r_lat_cnt;
        w_sweep_start = 1'b0;
        w_sweep_step  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    w_state_next  = ST_CLEAR;
                    w_ram_addr    = '0;
                    w_ram_wdata   = CLEAR_VALUE;
                    w_ram_we      = 1'b1;
                    w_clr_busy    = 1'b1;
                    w_sweep_start = 1'b1;
                end else if (bus.req_valid) begin
                    w_ram_addr = bus.req_addr;
                    if (bus.req_write) begin
                        w_ram_wdata  = bus.req_wdata;
                        w_ram_we     = 1'b1;
                        w_state_next = ST_WRITE;
                    end else begin
                        w_lat_cnt    = c_LAT_LOAD;
                        w_state_next = ST_RD_WAIT;
                    end
                end
            end

            ST_WRITE: begin
                w_rsp_valid  = 1'b1;
                w_state_next = ST_IDLE;
            end

            ST_RD_WAIT: begin
                // Counter hits zero on the edge after the RAM's data_out settles.
                if (r_lat_cnt == '0) begin
                    w_rsp_rdata  = bus.ram_rdata;
                    w_rsp_valid  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_lat_cnt = r_lat_cnt - c_LAT_CNT_W'(1);
                end
            end

            ST_CLEAR: begin
                w_sweep_step = 1'b1;
                w_ram_addr   = w_sweep_next;
                if (w_sweep_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_ram_we   = 1'b1;
                    w_clr_busy = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_access_ctrl
// Brief  : Self-checking bench for ram_access_ctrl with behavioural RAM models.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_access_ctrl;

    localparam int RL  = 1;
    localparam int RL2 = 3;

    typedef struct {
        logic       w;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic       is_rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_pulses = 0;
    int   done_total = 0;
    logic [7:0] last_rd = 8'h00;
    exp_t sbq[$];
    vec_t vecs[12];

    ram_access_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
    ram_access_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

    ram_access_ctrl #(.READ_LATENCY(RL)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    ram_access_ctrl #(.READ_LATENCY(RL2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAMs: registered read with 1 and 3 cycles of latency.
    logic [7:0] mem1[256];
    logic [7:0] mem2[256];
    logic [7:0] pipe1;
    logic [7:0] pipe2_0, pipe2_1, pipe2_2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= ~8'(i);
        end else if (bus1.ram_we) begin
            mem1[bus1.ram_addr] <= bus1.ram_wdata;
        end
        pipe1 <= mem1[bus1.ram_addr];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem2[i] <= ~8'(i);
        end else if (bus2.ram_we) begin
            mem2[bus2.ram_addr] <= bus2.ram_wdata;
        end
        pipe2_0 <= mem2[bus2.ram_addr];
        pipe2_1 <= pipe2_0;
        pipe2_2 <= pipe2_1;
    end

    assign bus1.ram_rdata = pipe1;
    assign bus2.ram_rdata = pipe2_2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic is_rd, input logic [7:0] d, input int c);
        exp_t e;
        if (is_rd) last_rd = d;
        e.is_rd = is_rd;
        e.data  = last_rd;
        e.cyc   = c;
        sbq.push_back(e);
    endfunction

    // Response scoreboard for the READ_LATENCY=1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.ram_we && !bus1.clr_busy) wr_pulses++;
            if (bus1.clr_done) done_total++;
            if (bus1.rsp_valid) begin
                check("rsp_expected", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    check("rsp_rdata", 32'(bus1.rsp_rdata), 32'(e.data));
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp, output int acc);
        bus1.req_valid = 1'b1;
        bus1.req_write = w;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        acc = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bus1.req_ready) begin
                acc = cyc + 1;
                push_exp(!w, exp, acc + (w ? 1 : RL + 1));
                break;
            end
        end
        check("accept_in_time", 32'(acc >= 0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Counts sweep cycles with a request held; optionally re-pulses clr_start mid-sweep.
    task automatic sweep_with_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                                  input logic [7:0] exp, input int repulse_at);
        int busy_cnt;
        int ready_bad;
        busy_cnt  = 0;
        ready_bad = 0;
        @(negedge clk);
        bus1.clr_start = 1'b1;
        bus1.req_valid = 1'b1;
        bus1.req_write = w;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        #1 check("clr_blocks_ready", 32'(bus1.req_ready), 32'd0);
        @(posedge clk);
        #1 bus1.clr_start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!bus1.clr_busy) break;
            busy_cnt++;
            if (bus1.req_ready) ready_bad++;
            bus1.clr_start = (busy_cnt == repulse_at);
        end
        bus1.clr_start = 1'b0;
        check("clr_busy_cycles", 32'(busy_cnt), 32'd256);
        check("ready_low_in_sweep", 32'(ready_bad), 32'd0);
        check("clr_done_pulse", 32'(bus1.clr_done), 32'd1);
        check("ready_after_sweep", 32'(bus1.req_ready), 32'd1);
        push_exp(!w, exp, cyc + 1 + (w ? 1 : RL + 1));
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int prev_acc;
        int seen;

        vecs[0]  = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[1]  = '{1'b1, 8'h02, 8'hAA, 8'h00};
        vecs[2]  = '{1'b1, 8'h03, 8'hF0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[4]  = '{1'b0, 8'h02, 8'h00, 8'hAA};
        vecs[5]  = '{1'b0, 8'h03, 8'h00, 8'hF0};
        vecs[6]  = '{1'b1, 8'h7F, 8'h55, 8'h00};
        vecs[7]  = '{1'b0, 8'h7F, 8'h00, 8'h55};
        vecs[8]  = '{1'b0, 8'h40, 8'h00, 8'hBF};
        vecs[9]  = '{1'b1, 8'hFE, 8'h01, 8'h00};
        vecs[10] = '{1'b0, 8'hFE, 8'h00, 8'h01};
        vecs[11] = '{1'b0, 8'h03, 8'h00, 8'hF0};

        rst = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.clr_start = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0;   bus2.clr_start = 1'b0;

        // Reset state and async drop of ram_we mid-sweep.
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus1.ram_we, bus1.ram_addr, bus1.ram_wdata, bus1.rsp_valid,
                                    bus1.rsp_rdata, bus1.clr_busy, bus1.clr_done}), 32'd0);
        check("reset_ready", 32'(bus1.req_ready), 32'd0);
        rst = 1'b0;
        #1 check("ready_after_reset", 32'(bus1.req_ready), 32'd1);
        bus1.clr_start = 1'b1;
        @(posedge clk);
        #1 bus1.clr_start = 1'b0;
        repeat (5) @(negedge clk);
        check("sweep_running", 32'({bus1.ram_we, bus1.clr_busy}), 32'd3);
        #2 rst = 1'b1;
        #1 check("async_reset_drop", 32'({bus1.ram_we, bus1.clr_busy, bus1.ram_addr}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rerelease", 32'(bus1.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Table of back-to-back writes and reads.
        prev_acc = 0;
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].exp, acc);
            if (i > 0)
                check("back_to_back_accept", 32'(acc),
                      32'(prev_acc + (vecs[i-1].w ? 2 : RL + 2)));
            prev_acc = acc;
        end
        bus1.req_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Clear beats a simultaneous read; the read then sees the cleared value.
        sweep_with_req(1'b0, 8'h02, 8'h00, 8'h00, 0);
        repeat (6) @(negedge clk);
        check("done_count_after_clear", 32'(done_total), 32'd1);

        // READ_LATENCY=3 instance: write then read back.
        bus2.req_valid = 1'b1; bus2.req_write = 1'b1;
        bus2.req_addr  = 8'h03; bus2.req_wdata = 8'h5C;
        #1 check("l3_write_ready", 32'(bus2.req_ready), 32'd1);
        @(posedge clk);
        #1 bus2.req_write = 1'b0;
        acc = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus2.req_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1 bus2.req_valid = 1'b0;
        seen = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus2.rsp_valid) begin
                seen = cyc;
                break;
            end
        end
        check("l3_rsp_cycle", 32'(seen), 32'(acc + RL2 + 1));
        check("l3_rsp_rdata", 32'(bus2.rsp_rdata), 32'h5C);

        // Sweep with held write and a clr_start pulse mid-sweep.
        sweep_with_req(1'b1, 8'h09, 8'h77, 8'h00, 100);
        do_req(1'b0, 8'h09, 8'h00, 8'h77, acc);
        do_req(1'b0, 8'h08, 8'h00, 8'h00, acc);
        bus1.req_valid = 1'b0;
        repeat (8) @(negedge clk);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        check("write_pulse_count", 32'(wr_pulses), 32'd6);
        check("done_count_total", 32'(done_total), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
